// File: rtl/color_match_judge.sv
// Colour-round judge: samples platform/ball colours, waits for a landing, scores hits,
// charges lives on misses or timeouts, and latches game over when lives run out.
module color_match_judge #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        new_color_plats,
  input  logic [2:0]         new_color_ball,
  input  logic               round_start,
  input  logic               land_valid,
  input  logic [1:0]         land_plat,
  output logic [11:0]        cur_plats,
  output logic [2:0]         cur_ball,
  output logic [3:0]         match_mask,
  output logic               reroll,
  output logic               hit,
  output logic               miss,
  output logic               timeout,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               game_over,
  output logic               armed
);

  localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;
  localparam logic [3:0] LivesInit = 4'(LIVES_INIT);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSample = 3'd1,
    StArmed  = 3'd2,
    StResult = 3'd3,
    StOver   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [11:0]         cur_plats_q, cur_plats_d;
  logic [2:0]          cur_ball_q, cur_ball_d;
  logic [3:0]          match_mask_q, match_mask_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          lives_q, lives_d;
  logic                reroll_q, reroll_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic                timeout_q, timeout_d;
  logic                game_over_q, game_over_d;
  logic                armed_q, armed_d;
  logic [3:0]          in_mask;

  always_comb begin
    in_mask = '0;
    for (int k = 0; k < 4; k++) begin
      in_mask[k] = (new_color_plats[3*k +: 3] == new_color_ball);
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_plats_d  = cur_plats_q;
    cur_ball_d   = cur_ball_q;
    match_mask_d = match_mask_q;
    timer_d      = timer_q;
    score_d      = score_q;
    lives_d      = lives_q;
    reroll_d     = 1'b0;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (round_start) state_d = StSample;
      end
      StSample: begin
        cur_plats_d  = new_color_plats;
        cur_ball_d   = new_color_ball;
        match_mask_d = in_mask;
        if (|in_mask) begin
          state_d = StArmed;
          timer_d = '0;
        end else begin
          reroll_d = 1'b1;
        end
      end
      StArmed: begin
        timer_d = timer_q + 1'b1;
        // A landing in the final timer cycle takes priority over the timeout.
        if (land_valid) begin
          state_d = StResult;
          if (match_mask_q[land_plat]) begin
            hit_d = 1'b1;
            if (score_q != ScoreMax) score_d = score_q + 1'b1;
          end else begin
            miss_d = 1'b1;
            if (lives_q != '0) lives_d = lives_q - 1'b1;
          end
        end else if (timer_q == TimerLast) begin
          state_d   = StResult;
          miss_d    = 1'b1;
          timeout_d = 1'b1;
          if (lives_q != '0) lives_d = lives_q - 1'b1;
        end
      end
      StResult: begin
        state_d = (lives_q == '0) ? StOver : StIdle;
      end
      StOver: begin
        state_d = StOver;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    armed_d     = (state_d == StArmed);
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cur_plats_q  <= '0;
      cur_ball_q   <= '0;
      match_mask_q <= '0;
      timer_q      <= '0;
      score_q      <= '0;
      lives_q      <= LivesInit;
      reroll_q     <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_plats_q  <= cur_plats_d;
      cur_ball_q   <= cur_ball_d;
      match_mask_q <= match_mask_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      reroll_q     <= reroll_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
      armed_q      <= armed_d;
    end
  end

  assign cur_plats  = cur_plats_q;
  assign cur_ball   = cur_ball_q;
  assign match_mask = match_mask_q;
  assign reroll     = reroll_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign timeout    = timeout_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_color_match_judge.sv
// Scoreboard bench for color_match_judge: directed rounds push expected judgements,
// a negedge monitor pops and compares whenever hit or miss is presented.
module tb_color_match_judge;

  localparam int unsigned SW = 2;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [11:0]   new_color_plats;
  logic [2:0]    new_color_ball;
  logic          round_start;
  logic          land_valid;
  logic [1:0]    land_plat;
  logic [11:0]   cur_plats;
  logic [2:0]    cur_ball;
  logic [3:0]    match_mask;
  logic          reroll;
  logic          hit;
  logic          miss;
  logic          timeout;
  logic [SW-1:0] score;
  logic [3:0]    lives;
  logic          game_over;
  logic          armed;

  always #5 clk = ~clk;

  color_match_judge #(
    .LIVES_INIT(3),
    .SCORE_W   (SW),
    .TIMEOUT   (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .new_color_plats(new_color_plats),
    .new_color_ball (new_color_ball),
    .round_start    (round_start),
    .land_valid     (land_valid),
    .land_plat      (land_plat),
    .cur_plats      (cur_plats),
    .cur_ball       (cur_ball),
    .match_mask     (match_mask),
    .reroll         (reroll),
    .hit            (hit),
    .miss           (miss),
    .timeout        (timeout),
    .score          (score),
    .lives          (lives),
    .game_over      (game_over),
    .armed          (armed)
  );

  typedef struct {
    logic hit;
    logic miss;
    logic tmo;
    int   score;
    int   lives;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   reroll_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented judgement against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reroll) reroll_cnt++;
    if (hit || miss) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_hit", int'(hit), int'(e.hit));
        check("sb_miss", int'(miss), int'(e.miss));
        check("sb_timeout", int'(timeout), int'(e.tmo));
        check("sb_score", int'(score), e.score);
        check("sb_lives", int'(lives), e.lives);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_score", int'(score), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_game_over", int'(game_over), 0);
    check("rst_armed", int'(armed), 0);
  endtask

  // Returns in the first ARMED cycle.
  task automatic arm(input logic [11:0] p, input logic [2:0] b, input logic [3:0] exp_mask);
    new_color_plats = p;
    new_color_ball  = b;
    round_start     = 1'b1;
    step();
    round_start = 1'b0;
    step();
    check("armed", int'(armed), 1);
    check("match_mask", int'(match_mask), int'(exp_mask));
    check("cur_ball", int'(cur_ball), int'(b));
  endtask

  // Lands now; returns two cycles later (IDLE or OVER).
  task automatic land(input logic [1:0] slot, input logic eh, input int es, input int el,
                      input logic eo);
    land_valid = 1'b1;
    land_plat  = slot;
    sb_q.push_back('{eh, ~eh, 1'b0, es, el});
    step();
    land_valid = 1'b0;
    step();
    check("sb_drained", sb_q.size(), 0);
    check("game_over", int'(game_over), int'(eo));
    check("armed_after", int'(armed), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0;
    reset           = 1'b1;
    new_color_plats = '0;
    new_color_ball  = '0;
    round_start     = 1'b0;
    land_valid      = 1'b0;
    land_plat       = '0;
    step();
    step();
    reset = 1'b0;
    check("init_cur_plats", int'(cur_plats), 0);
    check("init_mask", int'(match_mask), 0);
    check("init_lives", int'(lives), 3);
    check("init_score", int'(score), 0);
    check("init_reroll", int'(reroll), 0);

    // 1: slot colours 0,1,2,3; ball 2 lands on slot 2.
    arm(12'h688, 3'd2, 4'b0100);
    check("cur_plats", int'(cur_plats), 'h688);
    land(2'd2, 1'b1, 1, 3, 1'b0);

    // 2: wrong slot.
    arm(12'h688, 3'd2, 4'b0100);
    land(2'd0, 1'b0, 1, 2, 1'b0);

    // 3: three rerolls, then every slot matches.
    new_color_plats = 12'h000;
    new_color_ball  = 3'd5;
    round_start     = 1'b1;
    step();
    round_start = 1'b0;
    r0 = reroll_cnt;
    repeat (3) step();
    new_color_ball = 3'd0;
    step();
    check("reroll_count", reroll_cnt - r0, 3);
    check("armed_after_reroll", int'(armed), 1);
    check("mask_all", int'(match_mask), 'hf);
    land(2'd1, 1'b1, 2, 2, 1'b0);
    check("no_late_reroll", reroll_cnt - r0, 3);

    // 4a: timeout exactly TO cycles after ARMED entry.
    arm(12'h688, 3'd3, 4'b1000);
    repeat (TO - 1) step();
    @(negedge clk);
    #1;
    sb_q.push_back('{1'b0, 1'b1, 1'b1, 2, 1});
    step();
    step();
    check("tmo_drained", sb_q.size(), 0);
    check("tmo_armed", int'(armed), 0);

    // 4b: landing in the final timer cycle beats the timeout.
    arm(12'h688, 3'd3, 4'b1000);
    repeat (TO - 1) step();
    land(2'd3, 1'b1, 3, 1, 1'b0);

    // 5: three misses from a fresh game end it.
    do_reset();
    arm(12'h688, 3'd2, 4'b0100);
    land(2'd0, 1'b0, 0, 2, 1'b0);
    arm(12'h688, 3'd2, 4'b0100);
    land(2'd1, 1'b0, 0, 1, 1'b0);
    arm(12'h688, 3'd2, 4'b0100);
    land(2'd3, 1'b0, 0, 0, 1'b1);
    r0 = reroll_cnt;
    new_color_ball = 3'd5;
    round_start    = 1'b1;
    land_valid     = 1'b1;
    land_plat      = 2'd2;
    repeat (3) step();
    round_start = 1'b0;
    land_valid  = 1'b0;
    step();
    check("over_game_over", int'(game_over), 1);
    check("over_lives", int'(lives), 0);
    check("over_armed", int'(armed), 0);
    check("over_cur_ball", int'(cur_ball), 2);
    check("over_reroll", reroll_cnt - r0, 0);
    do_reset();

    // 6: score saturates at 3 with SCORE_W=2.
    for (int i = 0; i < 5; i++) begin
      arm(12'h688, 3'd2, 4'b0100);
      land(2'd2, 1'b1, (i + 1 > 3) ? 3 : i + 1, 3, 1'b0);
    end
    check("score_sat", int'(score), 3);

    // Reset while ARMED.
    arm(12'h688, 3'd1, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rarm_armed", int'(armed), 0);
    check("rarm_cur_plats", int'(cur_plats), 0);
    check("rarm_cur_ball", int'(cur_ball), 0);
    check("rarm_mask", int'(match_mask), 0);
    check("rarm_score", int'(score), 0);
    check("rarm_lives", int'(lives), 3);
    check("rarm_pulses", int'({hit, miss, timeout, reroll, game_over}), 0);
    step();
    check("final_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_match_judge.md
Name: color_match_judge

Overview:
Consumer end of the colour randomiser interface. Samples one round's platform colours (4 x 3-bit) and ball colour (3-bit) on request, waits for the ball to land, and judges whether the landing platform matches the ball colour. Tracks score and lives, and asserts game over. Sits between the randomiser and the game/VGA control logic.

Parameters:
LIVES_INIT, 3, lives loaded at reset (1..15)
SCORE_W, 8, score counter width
TIMEOUT, 1024, ARMED cycles allowed before a forced miss (>=2)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
new_color_plats  in  12  platform colours from randomiser; slot k = bits [3k+2:3k]
new_color_ball  in  3  ball colour from randomiser
round_start  in  1  one-cycle pulse requesting a new round
land_valid  in  1  one-cycle pulse; ball has landed
land_plat  in  2  platform slot index, valid with land_valid
cur_plats  out  12  latched platform colours for the current round
cur_ball  out  3  latched ball colour
match_mask  out  4  latched mask; bit k=1 iff cur_plats slot k == cur_ball
reroll  out  1  one-cycle pulse; sampled colours unusable, resampling
hit  out  1  one-cycle pulse; correct landing
miss  out  1  one-cycle pulse; wrong landing or timeout
timeout  out  1  one-cycle pulse, coincident with miss, when the miss was caused by timeout
score  out  SCORE_W  hit count, saturating
lives  out  4  remaining lives
game_over  out  1  level; high in OVER
armed  out  1  level; high in ARMED

Behaviour:
- Reset (synchronous, overrides everything, valid from any state):
  - state=IDLE, score=0, lives=LIVES_INIT.
  - cur_plats=0, cur_ball=0, match_mask=0, timer=0.
  - All pulses and levels are 0.
- State encoding: IDLE=0, SAMPLE=1, ARMED=2, RESULT=3, OVER=4. All outputs are registered.
- IDLE:
  - round_start=1 -> SAMPLE.
  - land_valid is ignored.
- SAMPLE:
  - Every cycle, latch new_color_plats/new_color_ball into cur_plats/cur_ball and compute match_mask from the input values.
  - If the mask is nonzero: go to ARMED and clear timer.
  - If the mask is zero: assert reroll for the next cycle and stay in SAMPLE, resampling each cycle until the mask is nonzero. There is no retry limit.
- ARMED:
  - armed=1; timer increments by 1 per cycle.
  - land_valid=1: evaluate match_mask[land_plat]. 1 -> hit, 0 -> miss. Go to RESULT.
  - Otherwise, if timer==TIMEOUT-1: miss with timeout, go to RESULT.
  - If land_valid and timeout occur in the same cycle, the landing wins.
  - round_start is ignored.
- Judgement register update (on the edge that leaves ARMED):
  - hit/miss/timeout are set for exactly one cycle (the RESULT cycle).
  - On hit: score increments, saturating at 2^SCORE_W-1.
  - On miss: lives decrements and never goes below 0.
- RESULT (one cycle):
  - If lives==0 -> OVER, else -> IDLE.
  - round_start during RESULT is dropped; it must be re-issued in IDLE.
- OVER:
  - game_over=1. All inputs are ignored; cur_* hold their values. Only reset exits OVER.
- Latency:
  - land_valid at cycle N -> hit/miss high at N+1, with score/lives already updated at N+1.
  - game_over high at N+2.
  - round_start at cycle N -> armed high at N+2 at the earliest (SAMPLE occupies N+1).
- Pulse exclusivity: hit and miss are never both high. reroll is high only in SAMPLE.
- cur_plats, cur_ball and match_mask are stable from ARMED through the next SAMPLE.
- land_plat is don't-care when land_valid=0.

Test Plan:
1. Reset, then round_start with plats=12'h688 (slots 0,1,2,3 = 0,1,2,3) and ball=2. land_valid with plat 2 -> match_mask=4'b0100, hit=1 one cycle, score=1, lives=3.
2. Same colours, land_plat=0 -> miss=1, timeout=0, lives=2, score unchanged. Return to IDLE.
3. Plats all 0 with ball=5 for 3 cycles, then ball=0 -> reroll pulses for 3 cycles, then ARMED with match_mask=4'b1111.
4. Arm with TIMEOUT=8 and no landing -> miss and timeout high exactly 8 cycles after ARMED entry, lives decrements. A second variant drives land_valid in the final timer cycle -> a landing result only, timeout=0.
5. Three consecutive misses from LIVES_INIT=3 -> lives=0, game_over=1 two cycles after the third land_valid. A further round_start and land_valid cause no change; reset restores lives=3, score=0, state IDLE.
6. SCORE_W=2 with 5 hits -> score sticks at 3. Assert reset while ARMED -> all outputs return to reset values on the next cycle.
